// File: rtl/alu_pkg.sv
// Shared ALU opcodes plus the limb sequencer's command and state encodings.
// The helper derives the carry fed into the lowest limb for each command kind.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001
    } alu_opc_e;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        ADC = 2'b10,
        SBC = 2'b11
    } seq_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

    // Subtraction runs as a + ~b + cin, so SUB starts with carry 1 and SBC with ~borrow.
    function automatic logic init_carry(input seq_op_e op, input logic cin);
        case (op)
            ADD:     return 1'b0;
            SUB:     return 1'b1;
            ADC:     return cin;
            SBC:     return ~cin;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_limb_seq.sv
// Wide ADD/SUB/ADC/SBC sequencer: drives the shared ALU one limb per cycle, LS limb first.
// Latency: accept, NLIMBS RUN cycles, then result held until res_ready; cmd_ready only in IDLE.
// Backpressure: result and flags are frozen while res_valid && !res_ready; no command queueing.
module alu_limb_seq
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = 16,
    parameter int NLIMBS    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic                        cmd_cin,
    input  logic [NLIMBS*REG_WIDTH-1:0] cmd_a,
    input  logic [NLIMBS*REG_WIDTH-1:0] cmd_b,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [NLIMBS*REG_WIDTH-1:0] res_data,
    output logic                        res_c,
    output logic                        res_v,
    output logic                        res_z,
    output logic [REG_WIDTH-1:0]        alu_ra,
    output logic [REG_WIDTH-1:0]        alu_rb,
    output logic                        alu_cin,
    output logic [2:0]                  alu_opc,
    input  logic [REG_WIDTH-1:0]        alu_out,
    input  logic                        alu_c,
    input  logic                        alu_v
);

    localparam int WW = NLIMBS * REG_WIDTH;
    localparam int IW = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NLIMBS - 1);

    seq_state_e      state;
    seq_op_e         op_in;
    logic [WW-1:0]   a_sh, b_sh, a_nx, b_nx, b_in;
    logic [IW-1:0]   idx;
    logic            is_sub;
    logic            zacc;
    logic            limb_zero;

    assign op_in     = seq_op_e'(cmd_op);
    assign b_in      = cmd_op[0] ? ~cmd_b : cmd_b;
    assign a_nx      = a_sh >> REG_WIDTH;
    assign b_nx      = b_sh >> REG_WIDTH;
    assign limb_zero = (alu_out == '0);

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign alu_opc   = ALU_ADD;

    // Operand shifters keep the next limb at the bottom so the ALU ports load from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            idx      <= '0;
            is_sub   <= 1'b0;
            zacc     <= 1'b0;
            res_data <= '0;
            res_c    <= 1'b0;
            res_v    <= 1'b0;
            res_z    <= 1'b0;
            alu_ra   <= '0;
            alu_rb   <= '0;
            alu_cin  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_sh    <= cmd_a;
                        b_sh    <= b_in;
                        alu_ra  <= cmd_a[REG_WIDTH-1:0];
                        alu_rb  <= b_in[REG_WIDTH-1:0];
                        alu_cin <= init_carry(op_in, cmd_cin);
                        idx     <= '0;
                        zacc    <= 1'b1;
                        is_sub  <= cmd_op[0];
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_data[idx*REG_WIDTH +: REG_WIDTH] <= alu_out;
                    zacc <= zacc & limb_zero;
                    idx  <= idx + 1'b1;
                    a_sh <= a_nx;
                    b_sh <= b_nx;
                    if (idx == LAST) begin
                        res_v   <= alu_v;
                        res_c   <= is_sub ^ alu_c;
                        res_z   <= zacc & limb_zero;
                        alu_ra  <= '0;
                        alu_rb  <= '0;
                        alu_cin <= 1'b0;
                        state   <= DONE;
                    end else begin
                        alu_ra  <= a_nx[REG_WIDTH-1:0];
                        alu_rb  <= b_nx[REG_WIDTH-1:0];
                        alu_cin <= alu_c;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_limb_seq.sv
// Directed bench for alu_limb_seq with a behavioural 16-bit ALU attached to its ALU ports.
module tb_alu_limb_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_cin;
    logic [63:0] cmd_a;
    logic [63:0] cmd_b;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_c;
    logic        res_v;
    logic        res_z;
    logic [15:0] alu_ra;
    logic [15:0] alu_rb;
    logic        alu_cin;
    logic [2:0]  alu_opc;
    logic [15:0] alu_out;
    logic        alu_c;
    logic        alu_v;
    logic [16:0] sum;

    int nvec = 0;
    int nerr = 0;

    alu_limb_seq #(.REG_WIDTH(16), .NLIMBS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_c(res_c), .res_v(res_v), .res_z(res_z),
        .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_cin(alu_cin), .alu_opc(alu_opc),
        .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v)
    );

    assign sum     = {1'b0, alu_ra} + {1'b0, alu_rb} + {16'd0, alu_cin};
    assign alu_out = sum[15:0];
    assign alu_c   = sum[16];
    assign alu_v   = (alu_ra[15] == alu_rb[15]) && (sum[15] != alu_ra[15]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic cin, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        chk("cmd_ready_before_send", {63'd0, cmd_ready}, 64'd1);
        cmd_op    = op;
        cmd_cin   = cin;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic get_res(input string tag, input logic [63:0] d, input logic c, input logic v, input logic z);
        int n;
        n = 0;
        res_ready = 1'b1;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
        chk({tag, "_data"}, res_data, d);
        chk({tag, "_c"}, {63'd0, res_c}, {63'd0, c});
        chk({tag, "_v"}, {63'd0, res_v}, {63'd0, v});
        chk({tag, "_z"}, {63'd0, res_z}, {63'd0, z});
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
        chk({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
        chk({tag, "_res_data"}, res_data, 64'd0);
        chk({tag, "_flags"}, {61'd0, res_c, res_v, res_z}, 64'd0);
        chk({tag, "_alu_ra"}, {48'd0, alu_ra}, 64'd0);
        chk({tag, "_alu_rb"}, {48'd0, alu_rb}, 64'd0);
        chk({tag, "_alu_cin"}, {63'd0, alu_cin}, 64'd0);
        chk({tag, "_alu_opc"}, {61'd0, alu_opc}, 64'd0);
    endtask

    initial begin
        logic [3:0] cin_seq;
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cin   = 1'b0;
        cmd_a     = 64'd0;
        cmd_b     = 64'd0;
        res_ready = 1'b0;
        #2;
        chk_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry rippling out of limb 0; latency and ALU carry chain
        cin_seq = 4'b0010;
        send(2'b00, 1'b0, 64'h0000_0000_0000_FFFF, 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("add_alu_cin_seq", {63'd0, alu_cin}, {63'd0, cin_seq[k]});
            chk("add_not_valid_in_run", {63'd0, res_valid}, 64'd0);
        end
        @(negedge clk);
        chk("add_latency_valid", {63'd0, res_valid}, 64'd1);
        get_res("add_ripple", 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);

        send(2'b01, 1'b0, 64'd0, 64'd1);
        get_res("sub_0_1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

        send(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        get_res("add_wrap", 64'd0, 1'b1, 1'b0, 1'b1);

        send(2'b00, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        get_res("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

        send(2'b10, 1'b1, 64'd0, 64'd0);
        get_res("adc_cin", 64'd1, 1'b0, 1'b0, 1'b0);

        send(2'b11, 1'b1, 64'd5, 64'd2);
        get_res("sbc_borrow", 64'd2, 1'b0, 1'b0, 1'b0);

        // Backpressure with stray cmd_valid pulses in RUN and DONE
        send(2'b00, 1'b0, 64'h1234, 64'h1111);
        @(negedge clk);
        chk("bp_cmd_ready_run", {63'd0, cmd_ready}, 64'd0);
        cmd_op = 2'b00; cmd_a = 64'd1; cmd_b = 64'd1; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", {63'd0, res_valid}, 64'd1);
            chk("bp_data", res_data, 64'h2345);
            chk("bp_flags", {61'd0, res_c, res_v, res_z}, 64'd0);
            chk("bp_cmd_ready_done", {63'd0, cmd_ready}, 64'd0);
            cmd_valid = (k == 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("bp_valid_fell", {63'd0, res_valid}, 64'd0);
        chk("bp_idle_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        chk("bp_no_queued_cmd", {63'd0, res_valid}, 64'd0);
        chk("bp_still_idle", {63'd0, cmd_ready}, 64'd1);

        // Asynchronous reset while limb 2 is on the ALU
        send(2'b00, 1'b0, 64'h1111_2222_3333_4444, 64'h0101_0202_0303_0404);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_alu_ra_limb2", {48'd0, alu_ra}, 64'h2222);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_run_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b00, 1'b0, 64'd3, 64'd4);
        get_res("post_rst_add", 64'd7, 1'b0, 1'b0, 1'b0);

        // Two commands held valid back to back
        @(negedge clk);
        cmd_op = 2'b01; cmd_cin = 1'b0; cmd_a = 64'd10; cmd_b = 64'd3; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_op = 2'b00; cmd_a = 64'h8000_0000_0000_0000; cmd_b = 64'h8000_0000_0000_0000;
        get_res("b2b_first", 64'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_idle_ready", {63'd0, cmd_ready}, 64'd1);
        chk("b2b_idle_valid", {63'd0, res_valid}, 64'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("b2b_second_accepted", {63'd0, cmd_ready}, 64'd0);
        get_res("b2b_second", 64'd0, 1'b1, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_limb_seq.md
Name: alu_limb_seq

Overview:
Multi-precision arithmetic sequencer for the single-width ALU. Accepts one wide ADD/SUB/ADC/SBC command of NLIMBS*REG_WIDTH bits and drives the shared ALU one limb per cycle, least-significant limb first, chaining carry through alu flagcin. Assembles the wide result and final flags and returns them over a valid/ready handshake. Sits between the execute stage and the ALU and owns the ALU ports while busy.

Parameters:
REG_WIDTH, 16, width of one ALU operand/limb
NLIMBS, 4, number of limbs per wide operation (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command (IDLE)
cmd_op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC
cmd_cin  input  1  carry-in for ADC; borrow-in for SBC (1 = borrow)
cmd_a  input  NLIMBS*REG_WIDTH  operand A
cmd_b  input  NLIMBS*REG_WIDTH  operand B
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_data  output  NLIMBS*REG_WIDTH  wide result
res_c  output  1  final carry (ADD/ADC) or final borrow (SUB/SBC)
res_v  output  1  signed overflow of the top limb
res_z  output  1  whole result is zero
alu_ra  output  REG_WIDTH  ALU operand a
alu_rb  output  REG_WIDTH  ALU operand b
alu_cin  output  1  ALU flagcin
alu_opc  output  3  ALU opcode
alu_out  input  REG_WIDTH  ALU result (combinational from alu_ra/rb/cin)
alu_c  input  1  ALU carry-out
alu_v  input  1  ALU overflow

Behaviour:
- Clock clk; reset rst_n asynchronous, active-low. All state is reset on assertion, regardless of current state.
- Reset values: state IDLE, cmd_ready=1, res_valid=0, res_data=0, res_c=0, res_v=0, res_z=0, alu_ra=0, alu_rb=0, alu_cin=0, alu_opc=ALU_ADD.
- ALU contract: opcode ALU_ADD (3'b000) computes ra+rb+flagcin with alu_c = carry-out. The sequencer only issues ALU_ADD. Subtraction is done as a + ~b + cin.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch a, b (b inverted for SUB/SBC), limb index i=0, and initial carry. Initial carry is ADD 0, SUB 1, ADC cmd_cin, SBC ~cmd_cin. Then go to RUN.
- RUN (cmd_ready=0):
  - Drive alu_ra = limb i of a, alu_rb = limb i of b, alu_cin = carry register.
  - Each cycle: write alu_out into res_data limb i, carry register <= alu_c, zero accumulator &= (alu_out==0), i++.
  - When i==NLIMBS-1: latch res_v <= alu_v and go to DONE.
- ALU outputs are driven from registered state only and are held at reset values outside RUN.
- DONE:
  - res_valid=1. res_c = carry register for ADD/ADC, ~carry register for SUB/SBC. res_z = zero accumulator.
  - res_data and all flags stay stable while res_valid && !res_ready.
  - On res_ready, go to IDLE; res_valid falls next cycle. res_data holds its last value.
- Latency: command accepted at edge 0; RUN occupies edges 1..NLIMBS; res_valid is high from cycle NLIMBS+1. Throughput is one command per NLIMBS+2 cycles minimum.
- cmd_valid outside IDLE is ignored and not queued. Command inputs are not sampled after acceptance.
- NLIMBS=1: exactly one RUN cycle, identical to a direct ALU op.
- The carry register is cleared on every accept. There is no state leakage between commands.
- Reset mid-RUN or mid-DONE: the operation is discarded and the block returns to reset values.

Decomposition:
- Shared package alu_pkg:
  - alu_opc_e (ALU_ADD=3'b000, ALU_SUB=3'b001), shared with alu.
  - seq_op_e (ADD, SUB, ADC, SBC).
  - seq_state_e (IDLE, RUN, DONE).
- Limb index counter width is $clog2(NLIMBS), minimum 1.
- No sub-module. Limb select/insert is indexed part-select within the block.

Test Plan:
All cases use REG_WIDTH=16, NLIMBS=4.
- ADD a=0x0000_0000_0000_FFFF, b=1 -> res_data=0x0000_0000_0001_0000, c=0, v=0, z=0; res_valid first high 5 cycles after accept; alu_cin sequence 0,1,0,0.
- SUB a=0, b=1 -> res_data=0xFFFF_FFFF_FFFF_FFFF, c(borrow)=1, v=0, z=0. ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> res_data=0, c=1, z=1.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> res_data=0x8000_0000_0000_0000, v=1, c=0. ADC a=0, b=0, cin=1 -> res_data=1. SBC a=5, b=2, cin=1 -> res_data=2, c=0.
- Backpressure: res_ready low 3 cycles -> res_valid, res_data and flags stable; cmd_ready=0; a cmd_valid pulse during RUN/DONE is not executed. After res_ready, the next command is accepted one cycle after res_valid falls.
- Reset asserted asynchronously mid-RUN at i=2 -> all outputs at reset values immediately. A subsequent ADD 3+4 returns 7 with c=0, z=0.
- Back-to-back: two commands held continuously valid -> second accepted the cycle after the first's handshake; results correct and in order.
